// File: rtl/auto_pilot_if.sv
// auto_pilot_if: detector/enable inputs and command outputs of the autopilot sequencer
interface auto_pilot_if;
   logic       enable;
   logic       front_detector;
   logic       back_detector;
   logic       left_detector;
   logic       right_detector;
   logic [2:0] cur;
   logic       turn_left_signal;
   logic       turn_right_signal;
   logic       move_forward_signal;
   logic       move_backward_signal;
   logic       place_barrier_signal;
   logic       destroy_barrier_signal;
   modport master (
      input  enable, front_detector, back_detector, left_detector, right_detector,
      output cur, turn_left_signal, turn_right_signal, move_forward_signal,
             move_backward_signal, place_barrier_signal, destroy_barrier_signal
   );
   modport slave (
      output enable, front_detector, back_detector, left_detector, right_detector,
      input  cur, turn_left_signal, turn_right_signal, move_forward_signal,
             move_backward_signal, place_barrier_signal, destroy_barrier_signal
   );
endinterface

// File: rtl/auto_pilot_seq.sv
// auto_pilot_seq: right-hand wall-following sequencer driving timed command levels
module auto_pilot_seq #(
   parameter int TURN_CYCLES   = 50_000_000,
   parameter int MOVE_CYCLES   = 50_000_000,
   parameter int PULSE_CYCLES  = 10_000_000,
   parameter int SETTLE_CYCLES = 5_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   auto_pilot_if.master  ap_io
);
   localparam int MAX_TM = TURN_CYCLES > MOVE_CYCLES ? TURN_CYCLES : MOVE_CYCLES;
   localparam int MAX_TP = PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int TW = $clog2(MAX_TM > MAX_TP ? MAX_TM : MAX_TP) + 1;
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
   localparam logic [TW-1:0] MOVE_LAST  = TW'(MOVE_CYCLES - 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_N   = TW'(SETTLE_CYCLES);
   typedef enum logic [2:0] {IDLE, SENSE, DECIDE, TURN_R, TURN_L, MOVE, PLACE, DESTROY} state_e;
   state_e          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [3:0]      sync1_q, sync2_q, prev_q, dq_q, dq_d;
   logic            uturn_q, uturn_d;
   logic [4:0]      cmd_q, cmd_d;
   logic [3:0]      det_raw;
   assign det_raw = {ap_io.front_detector, ap_io.back_detector, ap_io.left_detector, ap_io.right_detector};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         dq_q    <= '0;
         uturn_q <= 1'b0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sync1_q <= det_raw;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         dq_q    <= dq_d;
         uturn_q <= uturn_d;
         cmd_q   <= cmd_d;
      end
   end
   // tmr counts cycles spent in the current action; every expiry restarts it at zero
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      uturn_d = uturn_q;
      dq_d    = dq_q;
      case (state_q)
         IDLE: begin
            tmr_d   = '0;
            state_d = SENSE;
         end
         SENSE: begin
            tmr_d = (sync2_q == prev_q) ? tmr_q + 1'b1 : '0;
            if (tmr_d == SETTLE_N) begin
               state_d = DECIDE;
               dq_d    = sync2_q;
               tmr_d   = '0;
            end
         end
         DECIDE: begin
            tmr_d   = '0;
            state_d = !dq_q[0] ? TURN_R : !dq_q[3] ? MOVE : !dq_q[1] ? TURN_L : !dq_q[2] ? PLACE : DESTROY;
         end
         TURN_R, TURN_L: if (tmr_q == TURN_LAST) begin
            tmr_d   = '0;
            state_d = uturn_q ? TURN_R : MOVE;
            uturn_d = 1'b0;
         end
         MOVE: if (tmr_q == MOVE_LAST) begin
            tmr_d   = '0;
            state_d = SENSE;
         end
         PLACE: if (tmr_q == PULSE_LAST) begin
            tmr_d   = '0;
            state_d = TURN_R;
            uturn_d = 1'b1;
         end
         DESTROY: if (tmr_q == PULSE_LAST) begin
            tmr_d   = '0;
            state_d = SENSE;
         end
      endcase
      if (!ap_io.enable) begin
         state_d = IDLE;
         tmr_d   = '0;
         uturn_d = 1'b0;
      end
   end
   always_comb begin
      cmd_d = {state_d == TURN_L, state_d == TURN_R, state_d == MOVE, state_d == PLACE, state_d == DESTROY};
   end
   assign ap_io.cur                    = state_q;
   assign ap_io.turn_left_signal       = cmd_q[4];
   assign ap_io.turn_right_signal      = cmd_q[3];
   assign ap_io.move_forward_signal    = cmd_q[2];
   assign ap_io.move_backward_signal   = 1'b0;
   assign ap_io.place_barrier_signal   = cmd_q[1];
   assign ap_io.destroy_barrier_signal = cmd_q[0];
endmodule

// File: tb/tb_auto_pilot_seq.sv
// tb_auto_pilot_seq: directed test of the autopilot sequencer with small timing parameters
module tb_auto_pilot_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ncmp = 0;
   int   nbad = 0;
   logic [4:0] cmd_w;
   auto_pilot_if ap();
   auto_pilot_seq #(
      .TURN_CYCLES(3), .MOVE_CYCLES(4), .PULSE_CYCLES(2), .SETTLE_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ap_io(ap)
   );
   always #5 clk = ~clk;
   assign cmd_w = {ap.turn_left_signal, ap.turn_right_signal, ap.move_forward_signal,
                   ap.place_barrier_signal, ap.destroy_barrier_signal};
   function automatic logic [4:0] exp_cmd(input logic [2:0] code);
      return code == 3'd4 ? 5'b10000 : code == 3'd3 ? 5'b01000 : code == 3'd5 ? 5'b00100 :
             code == 3'd6 ? 5'b00010 : code == 3'd7 ? 5'b00001 : 5'b00000;
   endfunction
   task automatic check(input string tag, input logic [2:0] code);
      ncmp++;
      assert (ap.cur === code) else begin
         nbad++;
         $error("FAIL %s cur: got %0d expected %0d", tag, ap.cur, code);
      end
      ncmp++;
      assert (cmd_w === exp_cmd(code)) else begin
         nbad++;
         $error("FAIL %s cmd{tl,tr,mf,pb,db}: got %b expected %b", tag, cmd_w, exp_cmd(code));
      end
      ncmp++;
      assert ($onehot0(cmd_w) && ap.move_backward_signal === 1'b0) else begin
         nbad++;
         $error("FAIL %s onehot: got cmd=%b mb=%b expected one-hot-or-zero and mb=0", tag, cmd_w, ap.move_backward_signal);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run(input string tag, input logic [2:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check(tag, code);
      end
   endtask
   task automatic set_det(input logic [3:0] d);
      {ap.front_detector, ap.back_detector, ap.left_detector, ap.right_detector} = d;
   endtask
   task automatic wait_cur(input string tag, input logic [2:0] code, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (ap.cur !== code && n < budget);
      check(tag, code);
   endtask
   initial begin
      ap.enable = 1'b0;
      set_det(4'($urandom));
      repeat (3) begin
         step();
         set_det(4'($urandom));
         check("reset", 3'd0);
      end
      rst_n = 1'b1;
      set_det(4'b1110);
      run("idle_disabled", 3'd0, 4);
      ap.enable = 1'b1;
      run("s2_sense", 3'd1, 2);
      run("s2_decide", 3'd2, 1);
      run("s2_turn_r", 3'd3, 3);
      set_det(4'b0111);
      run("s2_move", 3'd5, 4);
      run("s3_sense", 3'd1, 2);
      run("s3_decide", 3'd2, 1);
      set_det(4'b1011);
      run("s3_move", 3'd5, 4);
      run("s4_sense", 3'd1, 2);
      run("s4_decide", 3'd2, 1);
      run("s4_place", 3'd6, 2);
      run("s4_turn1", 3'd3, 3);
      run("s4_turn2", 3'd3, 3);
      set_det(4'b1111);
      run("s4_move", 3'd5, 4);
      run("s5_sense", 3'd1, 2);
      run("s5_decide", 3'd2, 1);
      for (int i = 0; i < 2; i++) begin
         ap.right_detector = ~ap.right_detector;
         step();
         check("s5_destroy", 3'd7);
      end
      for (int i = 0; i < 10; i++) begin
         ap.right_detector = ~ap.right_detector;
         step();
         check("s5_toggle_sense", 3'd1);
      end
      set_det(4'b0111);
      wait_cur("s6_reach_move", 3'd5, 20);
      run("s6_move", 3'd5, 2);
      ap.enable = 1'b0;
      run("s6_abort", 3'd0, 3);
      ap.enable = 1'b1;
      wait_cur("s6_reenter_move", 3'd5, 20);
      #2 rst_n = 1'b0;
      #1 check("s6_async_reset", 3'd0);
      ap.enable = 1'b0;
      step();
      rst_n = 1'b1;
      run("s6_post_reset", 3'd0, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
